// File: rtl/db9md_pkg.sv
// Shared types for the Mega Drive / DB9 pad reader: button bit positions in the published
// word and the select-sequence phases.
package db9md_pkg;

   localparam int MD_WORD_W = 12;

   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_D     = 2;
   localparam int BTN_U     = 3;
   localparam int BTN_B     = 4;
   localparam int BTN_C     = 5;
   localparam int BTN_A     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_MODE  = 8;
   localparam int BTN_X     = 9;
   localparam int BTN_Y     = 10;
   localparam int BTN_Z     = 11;

   typedef enum logic [3:0] {IDLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7} phase_e;

   // Select is high while idle and in even phases, low in odd phases.
   function automatic logic sel_level(phase_e ph);
      return (ph == IDLE) || (ph == PH0) || (ph == PH2) || (ph == PH4) || (ph == PH6);
   endfunction

endpackage

// File: rtl/db9md_if.sv
// Pad-side and host-side signals of the DB9/MD reader; master is the reader itself.
interface db9md_if #(
   parameter int NUM_PORTS = 2
);
   import db9md_pkg::*;

   logic [5:0]                     joy_in;
   logic                           joy_mdsel;
   logic                           joy_split;
   logic [MD_WORD_W*NUM_PORTS-1:0] joystick;
   logic [NUM_PORTS-1:0]           pad_present;
   logic [NUM_PORTS-1:0]           md6;
   logic                           upd;

   modport master (
      input  joy_in,
      output joy_mdsel, joy_split, joystick, pad_present, md6, upd
   );

   modport slave (
      output joy_in,
      input  joy_mdsel, joy_split, joystick, pad_present, md6, upd
   );

endinterface

// File: rtl/db9md_port_capture.sv
// Per-port shadow of the button word built up across the select phases, copied to the
// published word only when the whole sequence for this port has completed.
module db9md_port_capture
   import db9md_pkg::*;
#(
   parameter bit FORCE_3BTN = 1'b0
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 active,
   input  phase_e               phase,
   input  logic                 sample,
   input  logic                 publish,
   input  logic [5:0]           pad_in,
   output logic [MD_WORD_W-1:0] word,
   output logic                 present,
   output logic                 six
);

   logic [MD_WORD_W-1:0] shadow_q, shadow_d;
   logic [MD_WORD_W-1:0] word_q, word_d;
   logic                 pres_sh_q, pres_sh_d;
   logic                 six_sh_q, six_sh_d;
   logic                 present_q, present_d;
   logic                 six_q, six_d;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         shadow_q  <= '0;
         word_q    <= '0;
         pres_sh_q <= 1'b0;
         six_sh_q  <= 1'b0;
         present_q <= 1'b0;
         six_q     <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         word_q    <= word_d;
         pres_sh_q <= pres_sh_d;
         six_sh_q  <= six_sh_d;
         present_q <= present_d;
         six_q     <= six_d;
      end
   end

   always_comb begin
      shadow_d  = shadow_q;
      word_d    = word_q;
      pres_sh_d = pres_sh_q;
      six_sh_d  = six_sh_q;
      present_d = present_q;
      six_d     = six_q;
      if (active && sample) begin
         case (phase)
            PH0: begin
               shadow_d[BTN_U] = ~pad_in[0];
               shadow_d[BTN_D] = ~pad_in[1];
               shadow_d[BTN_L] = ~pad_in[2];
               shadow_d[BTN_R] = ~pad_in[3];
               shadow_d[BTN_B] = ~pad_in[4];
               shadow_d[BTN_C] = ~pad_in[5];
            end
            PH1: begin
               shadow_d[BTN_A]     = ~pad_in[4];
               shadow_d[BTN_START] = ~pad_in[5];
               pres_sh_d           = (pad_in[3:2] == 2'b00);
            end
            PH5: six_sh_d = !FORCE_3BTN && (pad_in[3:0] == 4'b0000);
            PH6: begin
               if (six_sh_q) begin
                  shadow_d[BTN_Z]    = ~pad_in[0];
                  shadow_d[BTN_Y]    = ~pad_in[1];
                  shadow_d[BTN_X]    = ~pad_in[2];
                  shadow_d[BTN_MODE] = ~pad_in[3];
               end
            end
            default: ;
         endcase
      end
      // Upper nibble may hold stale 6-button data from an earlier pad; mask it unless six.
      if (active && publish) begin
         word_d = '0;
         if (pres_sh_q) begin
            word_d[7:0] = shadow_q[7:0];
            if (six_sh_q) word_d[11:8] = shadow_q[11:8];
         end
         present_d = pres_sh_q;
         six_d     = pres_sh_q && six_sh_q;
      end
   end

   assign word    = word_q;
   assign present = present_q;
   assign six     = six_q;

endmodule

// File: rtl/db9md_multi_reader.sv
// Mega Drive / DB9 pad reader: walks the select sequence on each port in turn and
// publishes one active-high 12-bit button word per port.
//
// state | meaning
// IDLE  | select high; pad counter times out; split already on the port to scan
// PH0   | select high; sample U/D/L/R/B/C
// PH1   | select low; sample A/Start; presence from L=R=0
// PH2-4 | select toggling to step the 6-button pad counter; no sample
// PH5   | select low; a 6-button pad answers with U/D/L/R all low
// PH6   | select high; sample Z/Y/X/Mode when 6-button
// PH7   | select low; publish (PH3 publishes instead when forced to 3-button)
module db9md_multi_reader
   import db9md_pkg::*;
#(
   parameter int NUM_PORTS    = 2,
   parameter int PHASE_CYCLES = 360,
   parameter int IDLE_CYCLES  = 32400,
   parameter bit FORCE_3BTN   = 1'b0
) (
   input  logic    clk_sys,
   input  logic    reset,
   db9md_if.master bus
);

   localparam int TMR_MAX = (PHASE_CYCLES > IDLE_CYCLES) ? PHASE_CYCLES : IDLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] PH_LOAD   = TMR_W'(PHASE_CYCLES - 1);
   localparam logic [TMR_W-1:0] IDLE_LOAD = TMR_W'(IDLE_CYCLES - 1);
   localparam phase_e LAST_PH = FORCE_3BTN ? PH3 : PH7;

   phase_e                          phase_q, phase_d;
   logic [TMR_W-1:0]                timer_q, timer_d;
   logic                            port_q, port_d;
   logic                            mdsel_q, mdsel_d;
   logic                            upd_q, upd_d;
   logic [5:0]                      sync1_q, sync1_d;
   logic [5:0]                      sync2_q, sync2_d;
   logic                            sample, publish;
   logic [MD_WORD_W-1:0]            word_w [NUM_PORTS];
   logic [NUM_PORTS-1:0]            present_w, six_w;
   logic [MD_WORD_W*NUM_PORTS-1:0]  joystick_w;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         phase_q <= IDLE;
         timer_q <= IDLE_LOAD;
         port_q  <= 1'b0;
         mdsel_q <= 1'b1;
         upd_q   <= 1'b0;
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         phase_q <= phase_d;
         timer_q <= timer_d;
         port_q  <= port_d;
         mdsel_q <= mdsel_d;
         upd_q   <= upd_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // Down-counter reloads on terminal count; the terminal cycle is the sample cycle.
   always_comb begin
      phase_d = phase_q;
      timer_d = timer_q - TMR_W'(1);
      port_d  = port_q;
      sample  = 1'b0;
      publish = 1'b0;
      sync1_d = bus.joy_in;
      sync2_d = sync1_q;
      if (timer_q == '0) begin
         timer_d = PH_LOAD;
         if (phase_q == IDLE) begin
            phase_d = PH0;
         end else begin
            sample = 1'b1;
            if (phase_q == LAST_PH) begin
               publish = 1'b1;
               phase_d = IDLE;
               timer_d = IDLE_LOAD;
               port_d  = (port_q == 1'(NUM_PORTS - 1)) ? 1'b0 : ~port_q;
            end else begin
               phase_d = phase_e'(phase_q + 4'd1);
            end
         end
      end
      mdsel_d = sel_level(phase_d);
      upd_d   = publish;
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      db9md_port_capture #(.FORCE_3BTN(FORCE_3BTN)) u_cap (
         .clk_sys (clk_sys),
         .reset   (reset),
         .active  (port_q == 1'(p)),
         .phase   (phase_q),
         .sample  (sample),
         .publish (publish),
         .pad_in  (sync2_q),
         .word    (word_w[p]),
         .present (present_w[p]),
         .six     (six_w[p])
      );
   end

   always_comb begin
      joystick_w = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         joystick_w[p*MD_WORD_W +: MD_WORD_W] = word_w[p];
      end
   end

   assign bus.joy_mdsel   = mdsel_q;
   assign bus.joy_split   = port_q;
   assign bus.joystick    = joystick_w;
   assign bus.pad_present = present_w;
   assign bus.md6         = six_w;
   assign bus.upd         = upd_q;

endmodule

// File: tb/tb_db9md_multi_reader.sv
// Bench for the DB9/MD reader: behavioural pads on two DUTs (2-port normal, 1-port forced
// 3-button), expected words and timing derived arithmetically from the sequence rules.
module tb_db9md_multi_reader;

   localparam int PH   = 4;
   localparam int IDL  = 8;
   localparam int PA   = IDL + 8*PH;
   localparam int PB   = IDL + 4*PH;
   localparam int NCYC = 2000;

   logic clk_sys = 1'b0;
   logic reset_a = 1'b1;
   logic reset_b = 1'b1;
   always #5 clk_sys = ~clk_sys;

   db9md_if #(.NUM_PORTS(2)) bus_a ();
   db9md_if #(.NUM_PORTS(1)) bus_b ();

   db9md_multi_reader #(.NUM_PORTS(2), .PHASE_CYCLES(PH), .IDLE_CYCLES(IDL), .FORCE_3BTN(1'b0))
      dut_a (.clk_sys(clk_sys), .reset(reset_a), .bus(bus_a));

   db9md_multi_reader #(.NUM_PORTS(1), .PHASE_CYCLES(PH), .IDLE_CYCLES(IDL), .FORCE_3BTN(1'b1))
      dut_b (.clk_sys(clk_sys), .reset(reset_b), .bus(bus_b));

   int nvec = 0;
   int nmis = 0;

   // pad kind: 0 none, 1 three-button, 2 six-button; held in published-word bit order
   int          kind_a [2];
   logic [11:0] held_a [2];
   logic [11:0] held_b;
   logic [11:0] exp_a [2];
   logic [1:0]  exp_pres_a, exp_md6_a;
   logic [11:0] exp_b;
   logic        exp_pres_b;
   int          na, nb, hold;
   bit          rst_done;
   int          cnt_a, hi_a, cnt_b, hi_b;
   logic        prev_a, prev_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] rnd_held();
      logic [11:0] h;
      h = 12'($urandom_range(0, 4095));
      if (h[3] && h[2]) h[2] = 1'b0;
      return h;
   endfunction

   function automatic logic [11:0] ref_word(int k, logic [11:0] h, bit force3);
      if (k == 0) return 12'h000;
      if (k == 2 && !force3) return h;
      return h & 12'h0FF;
   endfunction

   function automatic logic exp_sel(int n, int per);
      int m;
      m = n % per;
      if (m < IDL) return 1'b1;
      return (((m - IDL) / PH) % 2) == 0;
   endfunction

   // Real pad: answers according to select level and number of select falls since timeout.
   function automatic logic [5:0] pad_out(int k, logic [11:0] h, logic sel, int cnt);
      if (k == 0) return 6'h3F;
      if (k == 2 && cnt == 3 && sel) return ~{h[5], h[4], h[8], h[9], h[10], h[11]};
      if (k == 2 && cnt == 3 && !sel) return {~h[7], ~h[6], 4'h0};
      if (k == 2 && cnt == 4 && !sel) return {~h[7], ~h[6], 4'hF};
      if (sel) return ~{h[5], h[4], h[0], h[1], h[2], h[3]};
      return ~{h[7], h[6], 1'b1, 1'b1, h[2], h[3]};
   endfunction

   task automatic sched_a(input int s);
      int p;
      p = s % 2;
      if (s == 0) begin
         kind_a[0] = 1; held_a[0] = 12'h041;
      end else if (s == 1) begin
         kind_a[1] = 2; held_a[1] = 12'h980;
      end else if (s < 4) begin
         kind_a[p] = 0; held_a[p] = rnd_held();
      end else begin
         kind_a[p] = int'($urandom_range(0, 2)); held_a[p] = rnd_held();
      end
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_mdsel"}, bus_a.joy_mdsel, 1);
      chk({tag, "_split"}, bus_a.joy_split, 0);
      chk({tag, "_joystick"}, bus_a.joystick, 0);
      chk({tag, "_present"}, bus_a.pad_present, 0);
      chk({tag, "_md6"}, bus_a.md6, 0);
      chk({tag, "_upd"}, bus_a.upd, 0);
   endtask

   initial begin
      kind_a[0] = 0; kind_a[1] = 0;
      held_a[0] = '0; held_a[1] = '0; held_b = '0;
      exp_a[0] = '0; exp_a[1] = '0; exp_pres_a = '0; exp_md6_a = '0;
      exp_b = '0; exp_pres_b = 1'b0;
      hold = 0; rst_done = 1'b0;
      cnt_a = 0; hi_a = 0; prev_a = 1'b1;
      cnt_b = 0; hi_b = 0; prev_b = 1'b1;
      bus_a.joy_in = 6'h3F;
      bus_b.joy_in = 6'h3F;

      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_a("init");
      chk("init_b_joystick", bus_b.joystick, 0);

      na = 0; nb = 0;
      sched_a(0);
      held_b = 12'h210;
      bus_a.joy_in = pad_out(kind_a[0], held_a[0], 1'b1, 0);
      bus_b.joy_in = pad_out(2, held_b, 1'b1, 0);
      reset_a = 1'b0;
      reset_b = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk_sys);
         #1;
         na++;
         nb++;

         if (hold > 0) begin
            check_reset_a("hold");
            hold--;
            if (hold == 0) begin
               reset_a = 1'b0;
               na = 0;
               exp_a[0] = '0; exp_a[1] = '0; exp_pres_a = '0; exp_md6_a = '0;
               sched_a(0);
               rst_done = 1'b1;
            end
         end else begin
            if (na % PA == 0) begin
               int p;
               p = (na / PA - 1) % 2;
               exp_a[p]      = ref_word(kind_a[p], held_a[p], 1'b0);
               exp_pres_a[p] = (kind_a[p] != 0);
               exp_md6_a[p]  = (kind_a[p] == 2);
            end
            chk("a_mdsel", bus_a.joy_mdsel, exp_sel(na, PA));
            chk("a_split", bus_a.joy_split, (na / PA) % 2);
            chk("a_upd", bus_a.upd, (na % PA) == 0);
            chk("a_joystick", bus_a.joystick, {exp_a[1], exp_a[0]});
            chk("a_present", bus_a.pad_present, exp_pres_a);
            chk("a_md6", bus_a.md6, exp_md6_a);
            if (na == 40) begin
               chk("pin_3btn_word", bus_a.joystick[11:0], 12'h041);
               chk("pin_3btn_md6", bus_a.md6[0], 0);
               chk("pin_3btn_present", bus_a.pad_present[0], 1);
            end
            if (na == 80) begin
               chk("pin_6btn_word", bus_a.joystick[23:12], 12'h980);
               chk("pin_6btn_md6", bus_a.md6[1], 1);
               chk("pin_6btn_port0_kept", bus_a.joystick[11:0], 12'h041);
            end
            if (na == 120) begin
               chk("pin_nopad_word", bus_a.joystick[11:0], 12'h000);
               chk("pin_nopad_present", bus_a.pad_present[0], 0);
               chk("pin_nopad_upd", bus_a.upd, 1);
            end
            if (na % PA == 0) sched_a(na / PA);
            if (!rst_done && na >= 400 && (na % PA) == IDL + 3*PH) begin
               #1 reset_a = 1'b1;
               #1;
               check_reset_a("midseq");
               hold = 2;
            end
         end

         if (nb % PB == 0) begin
            exp_b      = ref_word(2, held_b, 1'b1);
            exp_pres_b = 1'b1;
         end
         chk("b_mdsel", bus_b.joy_mdsel, exp_sel(nb, PB));
         chk("b_split", bus_b.joy_split, 0);
         chk("b_upd", bus_b.upd, (nb % PB) == 0);
         chk("b_joystick", bus_b.joystick, exp_b);
         chk("b_present", bus_b.pad_present, exp_pres_b);
         chk("b_md6", bus_b.md6, 0);
         if (nb == 24) chk("pin_force3_word", bus_b.joystick, 12'h010);
         if (nb % PB == 0) held_b = rnd_held() | 12'h200;

         if (prev_a && !bus_a.joy_mdsel) cnt_a++;
         if (bus_a.joy_mdsel) hi_a++; else hi_a = 0;
         if (hi_a >= 6) cnt_a = 0;
         prev_a = bus_a.joy_mdsel;
         bus_a.joy_in = pad_out(kind_a[int'(bus_a.joy_split)], held_a[int'(bus_a.joy_split)],
                                bus_a.joy_mdsel, cnt_a);

         if (prev_b && !bus_b.joy_mdsel) cnt_b++;
         if (bus_b.joy_mdsel) hi_b++; else hi_b = 0;
         if (hi_b >= 6) cnt_b = 0;
         prev_b = bus_b.joy_mdsel;
         bus_b.joy_in = pad_out(2, held_b, bus_b.joy_mdsel, cnt_b);
      end

      if (!rst_done) chk("midseq_reset_reached", 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
